// File: rtl/cmn_entry_alloc2.sv
`default_nettype none
// ============================================================================
// Module   : cmn_entry_alloc2
// Purpose  : Dual-port entry allocator for a shared pool of ENTRY_NUM entries.
//            Grants up to two free entries per cycle (lowest index first),
//            tracks occupancy, retires released entries and provides a
//            drain handshake that blocks allocation until the pool is empty.
// Ports    : clk, rst (async, active-high)
//            alloc_req_0/1   in   allocation requests (port 0 has priority)
//            alloc_gnt_0/1   out  grant strobes, same cycle as request
//            alloc_idx_0/1   out  granted indices (valid with grant)
//            free_vec        in   multi-hot release mask
//            drain_req       in   start a drain
//            drain_done      out  one-cycle pulse when the drain completes
//            busy            out  allocator not in normal run state
//            used_cnt        out  occupied entry count
//            full / empty    out  derived from used_cnt
//            err_free        out  sticky: release of an unoccupied entry
// Revision : 1.0 - initial release
// ============================================================================
module cmn_entry_alloc2 #(
   parameter  int ENTRY_NUM = 8,
   localparam int IDX_W     = $clog2(ENTRY_NUM),
   localparam int CNT_W     = $clog2(ENTRY_NUM + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_req_0,
   input  logic                 alloc_req_1,
   output logic                 alloc_gnt_0,
   output logic [IDX_W-1:0]     alloc_idx_0,
   output logic                 alloc_gnt_1,
   output logic [IDX_W-1:0]     alloc_idx_1,
   input  logic [ENTRY_NUM-1:0] free_vec,
   input  logic                 drain_req,
   output logic                 drain_done,
   output logic                 busy,
   output logic [CNT_W-1:0]     used_cnt,
   output logic                 full,
   output logic                 empty,
   output logic                 err_free
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [ENTRY_NUM-1:0] c_ONE_HOT0 = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

   state_t                 r_state;
   state_t                 w_state_next;
   logic [ENTRY_NUM-1:0]   r_occ;
   logic [CNT_W-1:0]       r_used_cnt;
   logic                   r_err_free;

   logic                   w_first_vld;
   logic [IDX_W-1:0]       w_first_idx;
   logic                   w_second_vld;
   logic [IDX_W-1:0]       w_second_idx;
   logic                   w_en;
   logic                   w_gnt_0;
   logic                   w_gnt_1;
   logic [IDX_W-1:0]       w_idx_1;
   logic [ENTRY_NUM-1:0]   w_gnt_oh_0;
   logic [ENTRY_NUM-1:0]   w_gnt_oh_1;
   logic [ENTRY_NUM-1:0]   w_free_hit;
   logic [ENTRY_NUM-1:0]   w_free_bad;
   logic [CNT_W-1:0]       w_free_cnt;
   logic [CNT_W-1:0]       w_cnt_next;

   // Two lowest free indices from the registered occupancy vector.
   always_comb begin
      w_first_vld  = 1'b0;
      w_first_idx  = '0;
      w_second_vld = 1'b0;
      w_second_idx = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (!r_occ[i]) begin
            if (!w_first_vld) begin
               w_first_vld = 1'b1;
               w_first_idx = IDX_W'(i);
            end else if (!w_second_vld) begin
               w_second_vld = 1'b1;
               w_second_idx = IDX_W'(i);
            end
         end
      end
   end

   // Drain request blocks grants already in the cycle it is raised.
   assign w_en    = (r_state == ST_RUN) && !drain_req;
   // Grants are forced low while reset is held, since occupancy reads as
   // empty during reset and would otherwise look grantable.
   assign w_gnt_0 = !rst && alloc_req_0 && w_en && w_first_vld;
   // Port 1 takes the second free entry when port 0 consumed the first.
   assign w_gnt_1 = !rst && alloc_req_1 && w_en &&
                    (w_gnt_0 ? w_second_vld : w_first_vld);
   assign w_idx_1 = w_gnt_0 ? w_second_idx : w_first_idx;

   assign w_gnt_oh_0 = w_gnt_0 ? (c_ONE_HOT0 << w_first_idx) : '0;
   assign w_gnt_oh_1 = w_gnt_1 ? (c_ONE_HOT0 << w_idx_1)     : '0;

   // Only releases of occupied entries count; the rest flag an error.
   assign w_free_hit = free_vec & r_occ;
   assign w_free_bad = free_vec & ~r_occ;

   always_comb begin
      w_free_cnt = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_free_cnt = w_free_cnt + CNT_W'(w_free_hit[i]);
      end
   end

   assign w_cnt_next = r_used_cnt + CNT_W'(w_gnt_0) + CNT_W'(w_gnt_1) - w_free_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ      <= '0;
         r_used_cnt <= '0;
         r_err_free <= 1'b0;
      end else begin
         r_occ      <= (r_occ & ~free_vec) | w_gnt_oh_0 | w_gnt_oh_1;
         r_used_cnt <= w_cnt_next;
         r_err_free <= r_err_free | (|w_free_bad);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // DRAIN exits on the count the pool will hold after this edge, so the
   // done pulse appears the cycle right after the last occupied entry leaves.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:   if (drain_req) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_cnt_next == '0) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_RUN;
         default:  w_state_next = ST_RUN;
      endcase
   end

   assign alloc_gnt_0 = w_gnt_0;
   assign alloc_idx_0 = w_first_idx;
   assign alloc_gnt_1 = w_gnt_1;
   assign alloc_idx_1 = w_idx_1;
   assign drain_done  = (r_state == ST_DONE);
   assign busy        = (r_state != ST_RUN);
   assign used_cnt    = r_used_cnt;
   assign full        = (r_used_cnt == CNT_W'(ENTRY_NUM));
   assign empty       = (r_used_cnt == '0);
   assign err_free    = r_err_free;

endmodule
`default_nettype wire

// File: tb/tb_cmn_entry_alloc2.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmn_entry_alloc2
// Purpose  : Self-checking bench for cmn_entry_alloc2 (ENTRY_NUM = 8).
//            A behavioural pool model is compared against the DUT every
//            cycle; directed scenarios add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmn_entry_alloc2;

   localparam int N  = 8;
   localparam int IW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          alloc_req_0, alloc_req_1;
   logic          alloc_gnt_0, alloc_gnt_1;
   logic [IW-1:0] alloc_idx_0, alloc_idx_1;
   logic [N-1:0]  free_vec;
   logic          drain_req;
   logic          drain_done, busy, full, empty, err_free;
   logic [CW-1:0] used_cnt;

   always #5 clk = ~clk;

   cmn_entry_alloc2 #(.ENTRY_NUM(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .alloc_req_0 (alloc_req_0),
      .alloc_req_1 (alloc_req_1),
      .alloc_gnt_0 (alloc_gnt_0),
      .alloc_idx_0 (alloc_idx_0),
      .alloc_gnt_1 (alloc_gnt_1),
      .alloc_idx_1 (alloc_idx_1),
      .free_vec    (free_vec),
      .drain_req   (drain_req),
      .drain_done  (drain_done),
      .busy        (busy),
      .used_cnt    (used_cnt),
      .full        (full),
      .empty       (empty),
      .err_free    (err_free)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // m_mode: 0 = allocating, 1 = waiting for empty, 2 = drain complete
   logic [N-1:0] m_occ;
   int           m_mode;
   logic         m_err;

   function automatic int occ_count(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic void model_grants(output bit g0, output int i0,
                                        output bit g1, output int i1);
      int  fr[$];
      bit  en;
      int  k;
      for (int i = 0; i < N; i++) if (!m_occ[i]) fr.push_back(i);
      en = (m_mode == 0) && !drain_req;
      g0 = 0; g1 = 0; i0 = 0; i1 = 0;
      if (alloc_req_0 && en && fr.size() > 0) begin g0 = 1; i0 = fr[0]; end
      k = g0 ? 1 : 0;
      if (alloc_req_1 && en && fr.size() > k) begin g1 = 1; i1 = fr[k]; end
   endfunction

   always @(posedge clk or posedge rst) begin : mdl
      bit           g0, g1;
      int           i0, i1;
      logic [N-1:0] nocc;
      logic         nerr;
      int           nmode;
      if (rst) begin
         m_occ  <= '0;
         m_mode <= 0;
         m_err  <= 1'b0;
      end else begin
         model_grants(g0, i0, g1, i1);
         nocc = m_occ;
         nerr = m_err;
         for (int i = 0; i < N; i++) begin
            if (free_vec[i]) begin
               if (m_occ[i]) nocc[i] = 1'b0;
               else          nerr    = 1'b1;
            end
         end
         if (g0) nocc[i0] = 1'b1;
         if (g1) nocc[i1] = 1'b1;
         nmode = m_mode;
         if (m_mode == 0 && drain_req)                    nmode = 1;
         else if (m_mode == 1 && occ_count(nocc) == 0)    nmode = 2;
         else if (m_mode == 2)                            nmode = 0;
         m_occ  <= nocc;
         m_err  <= nerr;
         m_mode <= nmode;
      end
   end

   // Compare process: outputs checked mid-cycle against the model.
   always @(negedge clk) begin : cmp
      bit g0, g1;
      int i0, i1;
      if (!rst) begin
         model_grants(g0, i0, g1, i1);
         chk("m_gnt0", int'(alloc_gnt_0), int'(g0));
         chk("m_gnt1", int'(alloc_gnt_1), int'(g1));
         if (g0 && alloc_gnt_0) chk("m_idx0", int'(alloc_idx_0), i0);
         if (g1 && alloc_gnt_1) chk("m_idx1", int'(alloc_idx_1), i1);
         chk("m_used", int'(used_cnt), occ_count(m_occ));
         chk("m_full", int'(full), int'(occ_count(m_occ) == N));
         chk("m_empty", int'(empty), int'(occ_count(m_occ) == 0));
         chk("m_busy", int'(busy), int'(m_mode != 0));
         chk("m_done", int'(drain_done), int'(m_mode == 2));
         chk("m_err", int'(err_free), int'(m_err));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
      free_vec = '0; drain_req = 1'b0;
      #12;
      chk("rst_used", int'(used_cnt), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_gnt0", int'(alloc_gnt_0), 0);
      chk("rst_gnt1", int'(alloc_gnt_1), 0);
      chk("rst_err", int'(err_free), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Fill the pool two entries per cycle.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("fill_used", int'(used_cnt), 2 * k);
         if (k < 4) begin
            chk("fill_idx0", int'(alloc_idx_0), 2 * k);
            chk("fill_idx1", int'(alloc_idx_1), 2 * k + 1);
         end else begin
            chk("fill_full", int'(full), 1);
            chk("fill_nog0", int'(alloc_gnt_0), 0);
            chk("fill_nog1", int'(alloc_gnt_1), 0);
         end
         next_cycle();
      end

      // Free 2 and 5 while full; they are grantable only one cycle later.
      free_vec = 8'b0010_0100;
      @(negedge clk);
      chk("fr_nog0", int'(alloc_gnt_0), 0);
      chk("fr_nog1", int'(alloc_gnt_1), 0);
      next_cycle();
      free_vec = '0;
      @(negedge clk);
      chk("fr_used", int'(used_cnt), 6);
      chk("fr_idx0", int'(alloc_idx_0), 2);
      chk("fr_idx1", int'(alloc_idx_1), 5);
      next_cycle();
      alloc_req_0 = 1'b0; alloc_req_1 = 1'b0;
      @(negedge clk);
      chk("fr_used8", int'(used_cnt), 8);

      // Single free entry (7), both requesting: only port 0 served.
      free_vec = 8'h80;
      next_cycle();
      free_vec = '0; alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
      @(negedge clk);
      chk("one_gnt0", int'(alloc_gnt_0), 1);
      chk("one_idx0", int'(alloc_idx_0), 7);
      chk("one_gnt1", int'(alloc_gnt_1), 0);
      next_cycle();
      alloc_req_0 = 1'b0; alloc_req_1 = 1'b0;
      @(negedge clk);
      chk("one_full", int'(full), 1);

      // Leave only entry 0 occupied, then request from port 1 alone.
      free_vec = 8'hFE;
      next_cycle();
      free_vec = '0; alloc_req_1 = 1'b1;
      @(negedge clk);
      chk("p1_gnt0", int'(alloc_gnt_0), 0);
      chk("p1_gnt1", int'(alloc_gnt_1), 1);
      chk("p1_idx1", int'(alloc_idx_1), 1);
      next_cycle();
      alloc_req_1 = 1'b0; alloc_req_0 = 1'b1;   // takes entry 2
      next_cycle();
      alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;

      // Drain with three entries held, released one per cycle from N+2.
      drain_req = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         if (c == 1) drain_req = 1'b0;
         free_vec = (c >= 2 && c <= 4) ? N'(1 << (c - 2)) : '0;
         @(negedge clk);
         if (c == 0) chk("dr_used", int'(used_cnt), 3);
         if (c < 6) begin
            chk("dr_blk0", int'(alloc_gnt_0), 0);
            chk("dr_blk1", int'(alloc_gnt_1), 0);
            chk("dr_done", int'(drain_done), int'(c == 5));
         end else begin
            chk("dr_busy", int'(busy), 0);
            chk("dr_idx0", int'(alloc_idx_0), 0);
            chk("dr_idx1", int'(alloc_idx_1), 1);
         end
         if (c >= 1 && c <= 5) chk("dr_busyh", int'(busy), 1);
         next_cycle();
      end
      free_vec = '0; alloc_req_0 = 1'b0; alloc_req_1 = 1'b0;

      // Release an unoccupied entry: sticky error, count untouched.
      free_vec = 8'h10;
      next_cycle();
      free_vec = '0;
      @(negedge clk);
      chk("err_set", int'(err_free), 1);
      chk("err_used", int'(used_cnt), 2);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("err_hold", int'(err_free), 1);

      // Async reset in the middle of a drain.
      drain_req = 1'b1;
      next_cycle();
      drain_req = 1'b0;
      @(negedge clk);
      chk("ar_busy_pre", int'(busy), 1);
      alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("ar_used", int'(used_cnt), 0);
      chk("ar_empty", int'(empty), 1);
      chk("ar_busy", int'(busy), 0);
      chk("ar_done", int'(drain_done), 0);
      chk("ar_err", int'(err_free), 0);
      chk("ar_gnt0", int'(alloc_gnt_0), 0);
      next_cycle();
      next_cycle();
      rst = 1'b0; alloc_req_0 = 1'b0; alloc_req_1 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("ar_nodone", int'(drain_done), 0);
         next_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmn_entry_alloc2.md
# cmn_entry_alloc2

Dual-port entry allocator for a shared ENTRY_NUM-deep resource pool (request tables, MSHR-style slots, buffer entries). Each cycle it grants up to two free entries, lowest index first, tracks occupancy, and retires any set of entries released by consumers. A drain FSM blocks new allocations until the pool is empty, so upstream control can quiesce before a flush or reconfiguration.

## Interface
- ENTRY_NUM, 8, pool depth; ≥2, power of two not required
- IDX_W, $clog2(ENTRY_NUM), entry index width (derived, not overridden)
- CNT_W, $clog2(ENTRY_NUM+1), occupancy count width (derived)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_req_0  in  1  requester 0 wants one entry (priority port)
- alloc_req_1  in  1  requester 1 wants one entry
- alloc_gnt_0  out  1  entry granted to requester 0 this cycle
- alloc_idx_0  out  IDX_W  index granted to requester 0; valid only with alloc_gnt_0
- alloc_gnt_1  out  1  entry granted to requester 1 this cycle
- alloc_idx_1  out  IDX_W  index granted to requester 1; valid only with alloc_gnt_1
- free_vec  in  ENTRY_NUM  multi-hot mask of entries released this cycle
- drain_req  in  1  request to stop allocating and wait for empty
- drain_done  out  1  one-cycle pulse, pool empty after drain
- busy  out  1  FSM not in RUN
- used_cnt  out  CNT_W  number of occupied entries
- full  out  1  used_cnt == ENTRY_NUM
- empty  out  1  used_cnt == 0
- err_free  out  1  sticky: free_vec hit an unoccupied entry

## Operation
- State: occ[ENTRY_NUM] occupancy vector, used_cnt, FSM state, err_free.
- Free search over ~occ: first = lowest free index, second = next lowest free index.
- Grant enable en = (state == RUN) && !drain_req.
- Grant rules (combinational from registered occ, same cycle as request):
  - req0 && en && first exists -> gnt_0=1, idx_0=first.
  - req1 && en: if gnt_0, gnt_1 = second exists, idx_1=second; else gnt_1 = first exists, idx_1=first.
  - One free entry, both requesting -> only requester 0 granted.
  - No ungranted request is queued; requester re-asserts.
- Occupancy update at edge: occ_next = (occ & ~free_vec) | grant_oh_0 | grant_oh_1.
- Freed entry is not re-allocatable in the same cycle; it becomes grantable next cycle (no bypass).
- used_cnt_next = used_cnt + gnt_0 + gnt_1 − popcount(free_vec & occ); bits of free_vec on unoccupied entries ignored for count and set err_free (sticky until rst).
- full/empty derived from registered used_cnt.
- FSM:
  - RUN: drain_req=1 -> DRAIN.
  - DRAIN: allocations blocked; frees processed; used_cnt==0 -> DONE.
  - DONE: drain_done=1 for this cycle only; -> RUN unconditionally.
  - drain_req ignored in DRAIN/DONE; held high in RUN re-enters DRAIN next cycle.
- Reset mid-operation: all entries freed, FSM to RUN, pending drain abandoned (no drain_done).

## Timing
- Reset values: occ=0, used_cnt=0, empty=1, full=0, busy=0, drain_done=0, err_free=0, alloc_gnt_0/1=0 while rst asserted.
- Grant latency 0 cycles (combinational on registered occ); occupancy/count visible next cycle.
- Free latency: entry freed at edge N is grantable in cycle N+1.
- Drain: drain_req in cycle N blocks grants in N; busy=1 from N+1; drain_done earliest N+2 (pool already empty), back to RUN and grants allowed in N+3.
- Simultaneous alloc and free in one cycle: both applied; count net of both.
- full: no grants; empty and both request: grants idx 0 and 1.

## Test plan
- Reset, ENTRY_NUM=8, both req every cycle -> grants (0,1),(2,3),(4,5),(6,7); used_cnt 2,4,6,8; full=1; fifth cycle no grants.
- Full pool, free_vec=8'b0010_0100 with both req same cycle -> no grants that cycle; next cycle gnt_0 idx 2, gnt_1 idx 5; used_cnt 6 then 8.
- occ=8'b0111_1111, both req -> gnt_0 idx 7, gnt_1=0; full=1 next cycle.
- Only req1 with occ=8'b0000_0001 -> gnt_1 idx 1, gnt_0=0.
- occ=3 entries, drain_req pulse N, frees at N+2..N+4 -> no grants N..N+5, drain_done single pulse at N+5, grants resume N+6.
- free_vec bit on unoccupied entry -> err_free=1 next cycle and stays, used_cnt unchanged; async rst mid-DRAIN -> all outputs to reset values immediately, no drain_done.
